vram_scanout: RTL and testbench

- Downstream consumer of the dual-port video RAM's read-only port: generates raster timing and read addresses.
- Captures returned bytes, decodes 2bpp packed pixels (4 per byte) and emits a pixel index stream plus syncs/blanks to the palette/colour stage.
- Supports cocktail flip (screen rotated 180°).

---
 rtl/vram_scanout_pkg.sv | 28 ++
 rtl/vram_scanout_timing.sv | 76 +++++++
 rtl/vram_scanout.sv | 133 +++++++++++++
 tb/tb_vram_scanout.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vram_scanout_pkg.sv
// Shared constants and helpers for the VRAM scanout block.
// Holds the default raster timing, the derived bytes-per-line count and the
// 2bpp pixel decode used by the scanout shifter.
package vram_scanout_pkg;

    localparam int H_TOTAL_DEF   = 320;
    localparam int H_VISIBLE_DEF = 256;
    localparam int HS_START_DEF  = 272;
    localparam int HS_END_DEF    = 304;
    localparam int V_TOTAL_DEF   = 262;
    localparam int V_VISIBLE_DEF = 231;
    localparam int VS_START_DEF  = 240;
    localparam int VS_END_DEF    = 243;
    localparam int ADDR_W_DEF    = 14;

    localparam int BYTES_PER_LINE = H_VISIBLE_DEF / 4;

    // Pixel k (0 = leftmost) of a packed byte is {b[7-k], b[3-k]};
    // a flipped screen shows the pixels of each byte in reverse order.
    function automatic logic [1:0] pix_decode(input logic [7:0] b,
                                              input logic [1:0] k,
                                              input logic       flip);
        logic [2:0] i;
        i = {1'b0, (flip ? ~k : k)};
        return {b[3'd7 - i], b[3'd3 - i]};
    endfunction

endpackage

// File: rtl/vram_scanout_timing.sv
// video_timing: raster counters with registered blank/sync outputs.
//   clock, reset, ce_pix : clock, synchronous active-high reset, pixel enable
//   hcount, vcount       : current column / line (registered)
//   hblank, vblank       : high outside the visible area (registered)
//   hsync_n, vsync_n     : active-low syncs (registered)
//   active_next          : position being entered on the next ce_pix is visible
//   frame_start          : current position is the last-line prefetch slot
module video_timing
    import vram_scanout_pkg::*;
#(
    parameter int H_TOTAL   = H_TOTAL_DEF,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int HS_START  = HS_START_DEF,
    parameter int HS_END    = HS_END_DEF,
    parameter int V_TOTAL   = V_TOTAL_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int VS_START  = VS_START_DEF,
    parameter int VS_END    = VS_END_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce_pix,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       hblank,
    output logic       vblank,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       active_next,
    output logic       frame_start
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_PRE  = 9'(H_TOTAL - 4);
    localparam logic [8:0] H_VIS  = 9'(H_VISIBLE);
    localparam logic [8:0] HS_S   = 9'(HS_START);
    localparam logic [8:0] HS_E   = 9'(HS_END);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_VIS  = 9'(V_VISIBLE);
    localparam logic [8:0] VS_S   = 9'(VS_START);
    localparam logic [8:0] VS_E   = 9'(VS_END);

    logic [8:0] h_next;
    logic [8:0] v_next;

    always_comb begin
        h_next = (hcount == H_LAST) ? '0 : hcount + 9'd1;
        v_next = vcount;
        if (hcount == H_LAST) begin
            v_next = (vcount == V_LAST) ? '0 : vcount + 9'd1;
        end
        active_next = (h_next < H_VIS) && (v_next < V_VIS);
        frame_start = (hcount == H_PRE) && (vcount == V_LAST);
    end

    // Blank/sync are derived from the next position so they stay aligned
    // with the registered counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            hcount  <= '0;
            vcount  <= '0;
            hblank  <= 1'b0;
            vblank  <= 1'b0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
        end else if (ce_pix) begin
            hcount  <= h_next;
            vcount  <= v_next;
            hblank  <= (h_next >= H_VIS);
            vblank  <= (v_next >= V_VIS);
            hsync_n <= !((h_next >= HS_S) && (h_next < HS_E));
            vsync_n <= !((v_next >= VS_S) && (v_next < VS_E));
        end
    end

endmodule

// File: rtl/vram_scanout.sv
// vram_scanout: reads packed 2bpp bytes from the VRAM read port and emits a
// pixel index stream with raster timing, optionally rotated 180 degrees.
//   clock, reset, ce_pix : clock, synchronous active-high reset, pixel enable
//   flip                 : cocktail flip request, taken at frame start
//   vram_addr, vram_q    : VRAM port B address (registered) and read data
//   pix                  : pixel colour index, 0 while blanked
//   hblank, vblank       : blanking flags
//   hsync_n, vsync_n     : active-low syncs
//   hcount, vcount       : current column / line
module vram_scanout
    import vram_scanout_pkg::*;
#(
    parameter int H_TOTAL   = H_TOTAL_DEF,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int HS_START  = HS_START_DEF,
    parameter int HS_END    = HS_END_DEF,
    parameter int V_TOTAL   = V_TOTAL_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int VS_START  = VS_START_DEF,
    parameter int VS_END    = VS_END_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic              flip,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [7:0]        vram_q,
    output logic [1:0]        pix,
    output logic              hblank,
    output logic              vblank,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic [8:0]        hcount,
    output logic [8:0]        vcount
);

    localparam int         BPL    = H_VISIBLE / 4;
    localparam logic [8:0] H_PRE  = 9'(H_TOTAL - 4);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_VIS  = 9'(V_VISIBLE);
    localparam logic [6:0] G_LAST = 7'(BPL - 1);

    logic              active_next;
    logic              frame_start;
    logic [7:0]        hold_reg;
    logic [7:0]        shift_reg;
    logic              flip_latched;
    logic              flip_eff;
    logic              fetch_ok;
    logic [6:0]        grp;
    logic [6:0]        addr_g;
    logic [6:0]        col;
    logic [8:0]        addr_y;
    logic [8:0]        row;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        pix_src;
    logic [1:0]        k_next;

    video_timing #(
        .H_TOTAL  (H_TOTAL),
        .H_VISIBLE(H_VISIBLE),
        .HS_START (HS_START),
        .HS_END   (HS_END),
        .V_TOTAL  (V_TOTAL),
        .V_VISIBLE(V_VISIBLE),
        .VS_START (VS_START),
        .VS_END   (VS_END)
    ) u_timing (
        .clock      (clock),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .hcount     (hcount),
        .vcount     (vcount),
        .hblank     (hblank),
        .vblank     (vblank),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .active_next(active_next),
        .frame_start(frame_start)
    );

    // Fetch address: next group of this line, or group 0 of the next line in
    // the last group slot. Off-screen groups/lines hold the address so it
    // never leaves the frame buffer. The frame's first prefetch uses the flip
    // value being latched on that same ce_pix.
    always_comb begin
        grp      = hcount[8:2];
        flip_eff = frame_start ? flip : flip_latched;
        addr_y   = vcount;
        addr_g   = grp + 7'd1;
        fetch_ok = (grp < G_LAST);
        if (hcount == H_PRE) begin
            addr_y   = (vcount == V_LAST) ? '0 : vcount + 9'd1;
            addr_g   = '0;
            fetch_ok = 1'b1;
        end
        fetch_ok  = fetch_ok && (addr_y < V_VIS);
        row       = flip_eff ? (V_VIS - 9'd1 - addr_y) : addr_y;
        col       = flip_eff ? (G_LAST - addr_g) : addr_g;
        addr_next = ADDR_W'(row) * ADDR_W'(BPL) + ADDR_W'(col);

        // On the group boundary the byte moving into the shifter is shown
        // directly, so the first pixel of a group is not delayed a slot.
        pix_src = (hcount[1:0] == 2'd3) ? hold_reg : shift_reg;
        k_next  = hcount[1:0] + 2'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vram_addr    <= '0;
            hold_reg     <= '0;
            shift_reg    <= '0;
            flip_latched <= 1'b0;
            pix          <= '0;
        end else if (ce_pix) begin
            if ((hcount[1:0] == 2'd0) && fetch_ok) begin
                vram_addr <= addr_next;
            end
            if (hcount[1:0] == 2'd2) begin
                hold_reg <= vram_q;
            end
            if (hcount[1:0] == 2'd3) begin
                shift_reg <= hold_reg;
            end
            if (frame_start) begin
                flip_latched <= flip;
            end
            pix <= active_next ? pix_decode(pix_src, k_next, flip_latched) : '0;
        end
    end

endmodule

// File: tb/tb_vram_scanout.sv
module tb_vram_scanout;

    // Full-width lines, short frames so several frames fit the cycle budget.
    localparam int HT  = 320;
    localparam int HV  = 256;
    localparam int HSS = 272;
    localparam int HSE = 304;
    localparam int VT  = 8;
    localparam int VV  = 5;
    localparam int VSS = 6;
    localparam int VSE = 7;
    localparam int BPL = HV / 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce_pix = 1'b1;
    logic        flip = 1'b0;
    logic [13:0] vram_addr;
    logic [7:0]  vram_q;
    logic [1:0]  pix;
    logic        hblank, vblank, hsync_n, vsync_n;
    logic [8:0]  hcount, vcount;

    logic [7:0]  mem [0:16383];

    int   total = 0;
    int   bad = 0;
    int   mh = 0;
    int   mv = 0;
    bit   mflip = 1'b0;
    bit   first_line = 1'b1;
    logic [1:0] exp_pix = '0;

    always #5 clock = ~clock;

    always @(posedge clock) vram_q <= mem[vram_addr];

    vram_scanout #(
        .V_TOTAL  (VT),
        .V_VISIBLE(VV),
        .VS_START (VSS),
        .VS_END   (VSE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ce_pix   (ce_pix),
        .flip     (flip),
        .vram_addr(vram_addr),
        .vram_q   (vram_q),
        .pix      (pix),
        .hblank   (hblank),
        .vblank   (vblank),
        .hsync_n  (hsync_n),
        .vsync_n  (vsync_n),
        .hcount   (hcount),
        .vcount   (vcount)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (model h=%0d v=%0d)", tag, got, want, mh, mv);
        end
    endtask

    // Byte address of group g on screen line y.
    function automatic int ref_addr(input int y, input int g, input bit f);
        return f ? (VV - 1 - y) * BPL + (BPL - 1 - g) : y * BPL + g;
    endfunction

    // Colour of screen position (x, y) straight from frame-buffer contents.
    function automatic logic [1:0] ref_pix(input int x, input int y, input bit f);
        logic [7:0] b;
        int k;
        b = mem[ref_addr(y, x / 4, f)];
        k = f ? 3 - (x % 4) : x % 4;
        return {b[7 - k], b[3 - k]};
    endfunction

    task automatic do_reset(input int n);
        reset  = 1'b1;
        ce_pix = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            chk("rst_hcount", 16'(hcount), 16'd0);
            chk("rst_vcount", 16'(vcount), 16'd0);
            chk("rst_addr", 16'(vram_addr), 16'd0);
            chk("rst_pix", 16'(pix), 16'd0);
            chk("rst_hblank", 16'(hblank), 16'd0);
            chk("rst_vblank", 16'(vblank), 16'd0);
            chk("rst_hsync_n", 16'(hsync_n), 16'd1);
            chk("rst_vsync_n", 16'(vsync_n), 16'd1);
        end
        reset      = 1'b0;
        mh         = 0;
        mv         = 0;
        mflip      = 1'b0;
        first_line = 1'b1;
        exp_pix    = '0;
    endtask

    // gap idle clocks (ce_pix low), then one pixel step with full checking.
    task automatic tick(input int gap);
        int oh, ov, ny;
        for (int i = 0; i < gap; i++) begin
            ce_pix = 1'b0;
            @(posedge clock); #1;
            chk("hold_hcount", 16'(hcount), 16'(mh));
            chk("hold_pix", 16'(pix), 16'(exp_pix));
        end
        ce_pix = 1'b1;
        oh = mh;
        ov = mv;
        if (oh == HT - 4 && ov == VT - 1) mflip = flip;
        @(posedge clock); #1;
        mh = (oh + 1) % HT;
        mv = (mh == 0) ? (ov + 1) % VT : ov;
        if (mh == 0) first_line = 1'b0;

        if (mh < HV && mv < VV)
            exp_pix = (first_line && mh < 4) ? 2'd0 : ref_pix(mh, mv, mflip);
        else
            exp_pix = 2'd0;

        chk("hcount", 16'(hcount), 16'(mh));
        chk("vcount", 16'(vcount), 16'(mv));
        chk("hblank", 16'(hblank), 16'(mh >= HV));
        chk("vblank", 16'(vblank), 16'(mv >= VV));
        chk("hsync_n", 16'(hsync_n), 16'(!(mh >= HSS && mh < HSE)));
        chk("vsync_n", 16'(vsync_n), 16'(!(mv >= VSS && mv < VSE)));
        chk("pix", 16'(pix), 16'(exp_pix));

        if (oh % 4 == 0) begin
            if (oh == HT - 4) begin
                ny = (ov + 1) % VT;
                if (ny < VV) chk("addr_next_line", 16'(vram_addr), 16'(ref_addr(ny, 0, mflip)));
            end else if (oh / 4 < BPL - 1 && ov < VV) begin
                chk("addr_group", 16'(vram_addr), 16'(ref_addr(ov, oh / 4 + 1, mflip)));
            end
        end
    endtask

    task automatic run_to(input int v, input int h, input int gap);
        for (int n = 0; n < 2 * HT * VT; n++) begin
            tick(gap);
            if (mv == v && mh == h) break;
        end
    endtask

    initial begin
        for (int a = 0; a < 16384; a++) mem[a] = 8'hA5;

        // Reset held three clocks with ce_pix high.
        do_reset(3);

        // Constant 0xA5, unflipped: first frame (with the post-reset line) and a full frame.
        run_to(VT - 1, 200, 0);
        run_to(VT - 1, 200, 0);

        // Flip requested before frame start.
        flip = 1'b1;
        run_to(VT - 1, 200, 0);

        // Random contents, flipped frame; flip dropped mid-frame at line 2.
        for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom);
        run_to(2, 0, 0);
        flip = 1'b0;
        run_to(VT - 1, 200, 0);
        run_to(VT - 1, 200, 0);

        // New random contents with ce_pix high every third clock.
        for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom);
        run_to(VT - 1, 200, 2);

        // Reset in the middle of a line.
        run_to(1, 130, 0);
        do_reset(1);
        run_to(2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
